// File: rtl/jdv_moteur.sv
// ============================================================================
// jdv_moteur : Game of Life (B3/S23) engine, one cell per clock, atomic commit
// Rev 1.0
// ============================================================================
`default_nettype none

module jdv_moteur #(
    parameter int LARGEUR = 37,
    parameter int HAUTEUR = 38,
    parameter int N       = LARGEUR * HAUTEUR,
    parameter int PERIODE = 25000000
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          step,
    input  logic          run,
    input  logic          clear,
    input  logic          toggle,
    input  logic [31:0]   h_position_du_curseur,
    input  logic [31:0]   v_position_du_curseur,
    output logic [N-1:0]  vecteur_map,
    output logic          busy,
    output logic [15:0]   generation,
    output logic [10:0]   nb_vivantes
);

    localparam int c_IW = $clog2(N);
    localparam int c_XW = $clog2(LARGEUR);
    localparam int c_YW = $clog2(HAUTEUR);
    localparam int c_PW = $clog2(PERIODE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_n;
    logic [N-1:0]       r_map;
    logic [N-1:0]       r_shadow;
    logic [c_IW-1:0]    r_idx;
    logic [c_XW-1:0]    r_x;
    logic [c_YW-1:0]    r_y;
    logic [10:0]        r_acc;
    logic               r_pend;
    logic [c_IW-1:0]    r_pend_idx;
    logic [c_PW-1:0]    r_per;
    logic [15:0]        r_gen;
    logic [10:0]        r_nb;
    logic               r_busy;

    logic               w_tog_ok;
    logic [c_IW-1:0]    w_tog_idx;
    logic               w_start;
    logic [3:0]         w_nb;
    logic               w_next;
    logic               w_pend_v;
    logic [c_IW-1:0]    w_pend_i;
    logic [N-1:0]       w_pend_mask;

    assign w_tog_ok  = toggle
                     && (h_position_du_curseur < 32'(LARGEUR))
                     && (v_position_du_curseur < 32'(HAUTEUR));
    assign w_tog_idx = c_IW'(h_position_du_curseur[c_XW-1:0])
                     + c_IW'(v_position_du_curseur[c_YW-1:0]) * c_IW'(LARGEUR);
    assign w_start   = step || (run && (r_per == c_PW'(PERIODE - 1)));

    // Neighbour count of the cell under evaluation; off-grid cells read as dead.
    always_comb begin
        w_nb = '0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                int nx;
                int ny;
                nx = int'(r_x) + dx;
                ny = int'(r_y) + dy;
                if ((dx != 0 || dy != 0) && nx >= 0 && nx < LARGEUR
                    && ny >= 0 && ny < HAUTEUR) begin
                    w_nb = w_nb + 4'(r_map[c_IW'(nx + ny * LARGEUR)]);
                end
            end
        end
    end

    assign w_next = (w_nb == 4'd3) || (r_map[r_idx] && (w_nb == 4'd2));

    // A toggle landing on the commit edge supersedes the older pending one.
    assign w_pend_v    = w_tog_ok ? 1'b1 : r_pend;
    assign w_pend_i    = w_tog_ok ? w_tog_idx : r_pend_idx;
    assign w_pend_mask = w_pend_v ? ({{(N-1){1'b0}}, 1'b1} << w_pend_i) : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:    if (w_start) w_state_n = S_COMPUTE;
            S_COMPUTE: if (r_idx == c_IW'(N - 1)) w_state_n = S_COMMIT;
            S_COMMIT:  w_state_n = S_IDLE;
            default:   w_state_n = S_IDLE;
        endcase
        if (clear) begin
            w_state_n = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            r_map      <= '0;
            r_shadow   <= '0;
            r_idx      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_acc      <= '0;
            r_pend     <= 1'b0;
            r_pend_idx <= '0;
            r_per      <= '0;
            r_gen      <= '0;
            r_nb       <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_per <= (r_per == c_PW'(PERIODE - 1)) ? '0 : r_per + 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_tog_ok) begin
                        r_map[w_tog_idx] <= ~r_map[w_tog_idx];
                        r_nb <= r_map[w_tog_idx] ? r_nb - 11'd1 : r_nb + 11'd1;
                    end
                    if (w_start) begin
                        r_idx  <= '0;
                        r_x    <= '0;
                        r_y    <= '0;
                        r_acc  <= '0;
                        r_busy <= 1'b1;
                    end
                end
                S_COMPUTE: begin
                    r_shadow[r_idx] <= w_next;
                    r_acc <= r_acc + 11'(w_next);
                    r_idx <= r_idx + 1'b1;
                    if (r_x == c_XW'(LARGEUR - 1)) begin
                        r_x <= '0;
                        r_y <= r_y + 1'b1;
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                    if (w_tog_ok) begin
                        r_pend     <= 1'b1;
                        r_pend_idx <= w_tog_idx;
                    end
                end
                S_COMMIT: begin
                    r_map <= r_shadow ^ w_pend_mask;
                    if (w_pend_v) begin
                        r_nb <= r_shadow[w_pend_i] ? r_acc - 11'd1 : r_acc + 11'd1;
                    end else begin
                        r_nb <= r_acc;
                    end
                    r_gen  <= r_gen + 16'd1;
                    r_busy <= 1'b0;
                    r_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign vecteur_map = r_map;
    assign busy        = r_busy;
    assign generation  = r_gen;
    assign nb_vivantes = r_nb;

endmodule

`default_nettype wire

// File: tb/tb_jdv_moteur.sv
// ============================================================================
// tb_jdv_moteur : directed self-checking bench for the Game of Life engine
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_jdv_moteur;

    localparam int LARGEUR = 37;
    localparam int HAUTEUR = 38;
    localparam int N       = LARGEUR * HAUTEUR;
    localparam int PERIODE = 2000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          step;
    logic          run;
    logic          clear;
    logic          toggle;
    logic [31:0]   h_pos;
    logic [31:0]   v_pos;
    logic [N-1:0]  vecteur_map;
    logic          busy;
    logic [15:0]   generation;
    logic [10:0]   nb_vivantes;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    jdv_moteur #(
        .LARGEUR (LARGEUR),
        .HAUTEUR (HAUTEUR),
        .PERIODE (PERIODE)
    ) u_dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .step                  (step),
        .run                   (run),
        .clear                 (clear),
        .toggle                (toggle),
        .h_position_du_curseur (h_pos),
        .v_position_du_curseur (v_pos),
        .vecteur_map           (vecteur_map),
        .busy                  (busy),
        .generation            (generation),
        .nb_vivantes           (nb_vivantes)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tog(input int x, input int y);
        h_pos  = 32'(x);
        v_pos  = 32'(y);
        toggle = 1'b1;
        tick();
        toggle = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            tick();
            n++;
        end
        check("idle_wait", int'(busy), 0);
    endtask

    // Expected map from up to four live bit indices (negative = unused).
    function automatic logic [N-1:0] mk(input int a, input int b, input int c, input int d);
        logic [N-1:0] m = '0;
        if (a >= 0) m[a] = 1'b1;
        if (b >= 0) m[b] = 1'b1;
        if (c >= 0) m[c] = 1'b1;
        if (d >= 0) m[d] = 1'b1;
        return m;
    endfunction

    task automatic check_map(input string tag, input logic [N-1:0] exp);
        check(tag, $countones(vecteur_map ^ exp), 0);
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        step    = 1'b0;
        run     = 1'b0;
        clear   = 1'b0;
        toggle  = 1'b0;
        h_pos   = '0;
        v_pos   = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check_map("reset_map", '0);
        check("reset_busy", int'(busy), 0);
        check("reset_gen", int'(generation), 0);
        check("reset_nb", int'(nb_vivantes), 0);

        // Blinker
        tog(10, 10); tog(11, 10); tog(12, 10);
        check("blk_seed_nb", int'(nb_vivantes), 3);
        check_map("blk_seed_map", mk(380, 381, 382, -1));
        pulse_step();
        n = 0;
        while (busy && n < 3000) begin
            n++;
            tick();
        end
        check("blk_busy_cycles", n, 1407);
        check_map("blk_gen1_map", mk(344, 381, 418, -1));
        check("blk_gen1_gen", int'(generation), 1);
        check("blk_gen1_nb", int'(nb_vivantes), 3);
        pulse_step();
        wait_idle();
        check_map("blk_gen2_map", mk(380, 381, 382, -1));
        check("blk_gen2_gen", int'(generation), 2);

        // Out-of-range toggles are ignored
        tog(37, 0); tog(0, 38);
        check("oor_nb", int'(nb_vivantes), 3);
        check_map("oor_map", mk(380, 381, 382, -1));

        pulse_clear();
        check_map("clr_map", '0);
        check("clr_gen", int'(generation), 0);
        check("clr_nb", int'(nb_vivantes), 0);

        // Right edge, no wrap
        tog(36, 5); tog(36, 6); tog(36, 7);
        pulse_step();
        wait_idle();
        check_map("edge_map", mk(257, 258, -1, -1));
        check("edge_nb", int'(nb_vivantes), 2);
        check("edge_wrap_bit", int'(vecteur_map[222]), 0);

        // Corner block
        pulse_clear();
        tog(0, 0); tog(1, 0); tog(0, 1);
        pulse_step();
        wait_idle();
        check_map("blk4_map1", mk(0, 1, 37, 38));
        check("blk4_nb", int'(nb_vivantes), 4);
        check("blk4_gen1", int'(generation), 1);
        pulse_step();
        wait_idle();
        check_map("blk4_map2", mk(0, 1, 37, 38));
        check("blk4_gen2", int'(generation), 2);

        // Toggle while busy on an empty grid
        pulse_clear();
        pulse_step();
        repeat (100) tick();
        tog(5, 5);
        check_map("tbusy_map_during", '0);
        check("tbusy_busy", int'(busy), 1);
        pulse_step();
        repeat (50) tick();
        pulse_step();
        wait_idle();
        check_map("tbusy_map_after", mk(190, -1, -1, -1));
        check("tbusy_nb", int'(nb_vivantes), 1);
        check("tbusy_gen", int'(generation), 1);
        repeat (2000) tick();
        check("tbusy_no_extra_gen", int'(generation), 1);

        // Clear mid-compute
        tog(10, 10); tog(11, 10); tog(12, 10);
        pulse_step();
        repeat (499) tick();
        pulse_clear();
        check("cmid_busy", int'(busy), 0);
        check_map("cmid_map", '0);
        check("cmid_gen", int'(generation), 0);
        check("cmid_nb", int'(nb_vivantes), 0);
        repeat (2000) tick();
        check("cmid_no_commit_gen", int'(generation), 0);
        check_map("cmid_no_commit_map", '0);

        // Auto-run
        pulse_clear();
        tog(10, 10); tog(11, 10); tog(12, 10);
        run = 1'b1;
        repeat (10000) tick();
        run = 1'b0;
        wait_idle();
        check("auto_gen", int'(generation), 5);
        check_map("auto_map", mk(344, 381, 418, -1));
        check("auto_nb", int'(nb_vivantes), 3);
        repeat (4000) tick();
        check("auto_stopped_gen", int'(generation), 5);
        check_map("auto_stopped_map", mk(344, 381, 418, -1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
